// File: rtl/gate_tt_checker.sv
// Self-test sequencer for the two-input gate block: sweeps {A,B} through the truth table and scores Y.
// Optional macro GATE_CHK_STOP_ON_ERR_EN: end the sweep at the first vector that shows a mismatch.
module gate_tt_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERRCNT_W      = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  output logic                a_o,
  output logic                b_o,
  input  logic [5:0]          y_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [5:0]          errMask_o,
  output logic [ERRCNT_W-1:0] errCnt_o
);

  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam int PW = $clog2(PASSES) + 1;
  localparam logic [ERRCNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISH} state_t;

  state_t                state_q;
  logic [SW-1:0]         settle_q;
  logic [1:0]            vec_q;
  logic [PW-1:0]         passIdx_q;
  logic                  a_q, b_q, busy_q, done_q, passFlag_q;
  logic [5:0]            errMask_q;
  logic [ERRCNT_W-1:0]   errCnt_q;

  logic [5:0]            expY, mis;
  logic [2:0]            misPop;
  logic [ERRCNT_W+2:0]   cntSum;
  logic [5:0]            errMask_d;
  logic [ERRCNT_W-1:0]   errCnt_d;
  logic                  lastVec, stopNow;

  // Golden gate outputs for the vector currently on A/B, and the scoring of Y against them.
  always_comb begin
    expY      = {~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), ~(a_q & b_q), a_q | b_q, a_q & b_q};
    mis       = y_i ^ expY;
    misPop    = 3'($countones(mis));
    cntSum    = {3'b000, errCnt_q} + {{ERRCNT_W{1'b0}}, misPop};
    errMask_d = errMask_q | mis;
    errCnt_d  = (cntSum > {3'b000, CNT_MAX}) ? CNT_MAX : cntSum[ERRCNT_W-1:0];
    lastVec   = (vec_q == 2'd3) && (passIdx_q == PW'(PASSES - 1));
`ifdef GATE_CHK_STOP_ON_ERR_EN
    stopNow   = lastVec || (mis != 6'd0);
`else
    stopNow   = lastVec;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      vec_q      <= '0;
      passIdx_q  <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      passFlag_q <= 1'b0;
      errMask_q  <= '0;
      errCnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= DRIVE;
            busy_q     <= 1'b1;
            settle_q   <= '0;
            vec_q      <= '0;
            passIdx_q  <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            passFlag_q <= 1'b0;
            errMask_q  <= '0;
            errCnt_q   <= '0;
          end
        end
        DRIVE: begin
          if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
            state_q <= SAMPLE;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        SAMPLE: begin
          errMask_q <= errMask_d;
          errCnt_q  <= errCnt_d;
          settle_q  <= '0;
          if (stopNow) begin
            state_q    <= FINISH;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            passFlag_q <= (errMask_d == 6'd0);
          end else begin
            // Vector index wraps 3 -> 0 at the end of each pass.
            state_q      <= DRIVE;
            vec_q        <= vec_q + 2'd1;
            {a_q, b_q}   <= vec_q + 2'd1;
            if (vec_q == 2'd3) begin
              passIdx_q <= passIdx_q + 1'b1;
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign a_o       = a_q;
  assign b_o       = b_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pass_o    = passFlag_q;
  assign errMask_o = errMask_q;
  assign errCnt_o  = errCnt_q;

endmodule
